// File: rtl/sid_regfile.sv
// SID bus-side register file: per-voice waveform/envelope regs, filter regs, POT/OSC3/ENV3 readback and the decaying bus latch.
// Optional: define SID_BUS_DECAY_EN to let the bus latch decay after a model-dependent lifetime.
package sid;
  typedef enum logic {MOS6581 = 1'b0, MOS8580 = 1'b1} model_e;

  typedef logic [3:0] phase_t;
  localparam int unsigned PHI1_PHI2 = 0;
  localparam int unsigned PHI2_PHI1 = 1;
  localparam int unsigned PHI2      = 2;
  localparam int unsigned PHI1      = 3;

  typedef struct packed {
    logic [7:0] freq_lo;
    logic [7:0] freq_hi;
    logic [7:0] pw_lo;
    logic [7:0] pw_hi;
    logic       noise;
    logic       pulse;
    logic       sawtooth;
    logic       triangle;
    logic       test;
    logic       ring_mod;
    logic       sync;
  } waveform_reg_t;
endpackage

module sid_voice_regs (
  input  logic               clk,
  input  logic               res_n,
  input  logic               wr,
  input  logic [2:0]         off,
  input  logic [7:0]         data,
  output sid::waveform_reg_t voice,
  output logic [16:0]        env
);
  logic [7:0] freq_lo, freq_hi, pw_lo, ctrl, ad, sr;
  logic [3:0] pw_hi;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      freq_lo <= '0;
      freq_hi <= '0;
      pw_lo   <= '0;
      pw_hi   <= '0;
      ctrl    <= '0;
      ad      <= '0;
      sr      <= '0;
    end else if (wr) begin
      case (off)
        3'd0:    freq_lo <= data;
        3'd1:    freq_hi <= data;
        3'd2:    pw_lo   <= data;
        3'd3:    pw_hi   <= data[3:0];
        3'd4:    ctrl    <= data;
        3'd5:    ad      <= data;
        3'd6:    sr      <= data;
        default: ;
      endcase
    end
  end

  assign voice.freq_lo  = freq_lo;
  assign voice.freq_hi  = freq_hi;
  assign voice.pw_lo    = pw_lo;
  assign voice.pw_hi    = {4'h0, pw_hi};
  assign voice.noise    = ctrl[7];
  assign voice.pulse    = ctrl[6];
  assign voice.sawtooth = ctrl[5];
  assign voice.triangle = ctrl[4];
  assign voice.test     = ctrl[3];
  assign voice.ring_mod = ctrl[2];
  assign voice.sync     = ctrl[1];
  assign env            = {ctrl[0], ad, sr};
endmodule

module sid_regfile #(
  parameter logic [9:0] BUS_TTL_6581 = 10'd7,
  parameter logic [9:0] BUS_TTL_8580 = 10'd664
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               tick_ms,
  input  sid::model_e        model,
  input  sid::phase_t        phase,
  input  logic               cs,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [7:0]         data_i,
  output logic [7:0]         data_o,
  input  logic [7:0]         pot_x_i,
  input  logic [7:0]         pot_y_i,
  input  logic [7:0]         osc3_i,
  input  logic [7:0]         env3_i,
  output sid::waveform_reg_t voice_o [0:2],
  output logic [16:0]        env_o   [0:2],
  output logic [31:0]        filter_o
);
  localparam int NUM_VOICES = 3;

  logic access, wr, rd, rd_io, expire;
  logic [7:0] bus_latch, rd_val;
  logic [2:0] fc_lo;
  logic [7:0] fc_hi, res_filt, mode_vol;
  logic unused_phase;

  assign access       = cs & phase[sid::PHI2_PHI1];
  assign wr           = access & we;
  assign rd           = access & ~we;
  assign unused_phase = ^phase;

  // Voice n owns addresses 7n..7n+6; the wrapped difference keeps the range test one-sided.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    localparam logic [4:0] BASE = 5'(7 * v);
    logic [4:0] rel;
    assign rel = addr - BASE;
    sid_voice_regs u_voice (
      .clk   (clk),
      .res_n (res_n),
      .wr    (wr && (rel < 5'd7)),
      .off   (rel[2:0]),
      .data  (data_i),
      .voice (voice_o[v]),
      .env   (env_o[v])
    );
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      fc_lo    <= '0;
      fc_hi    <= '0;
      res_filt <= '0;
      mode_vol <= '0;
    end else if (wr) begin
      case (addr)
        5'h15:   fc_lo    <= data_i[2:0];
        5'h16:   fc_hi    <= data_i;
        5'h17:   res_filt <= data_i;
        5'h18:   mode_vol <= data_i;
        default: ;
      endcase
    end
  end

  assign filter_o = {mode_vol, res_filt, fc_hi, 5'b0, fc_lo};

  always_comb begin
    rd_val = bus_latch;
    rd_io  = 1'b1;
    case (addr)
      5'h19:   rd_val = pot_x_i;
      5'h1A:   rd_val = pot_y_i;
      5'h1B:   rd_val = osc3_i;
      5'h1C:   rd_val = env3_i;
      default: rd_io  = 1'b0;
    endcase
  end

`ifdef SID_BUS_DECAY_EN
  logic [9:0] age, age_nxt, ttl;

  // Expiry compares against the post-edge age so the latch clears on the same edge the lifetime is reached.
  always_comb begin
    ttl     = (model == sid::MOS8580) ? BUS_TTL_8580 : BUS_TTL_6581;
    age_nxt = age;
    if (access)
      age_nxt = '0;
    else if (tick_ms && age != 10'h3FF)
      age_nxt = age + 10'd1;
    expire = !access && (age_nxt >= ttl);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) age <= '0;
    else        age <= age_nxt;
  end
`else
  logic unused_decay;
  assign unused_decay = ^{tick_ms, model, BUS_TTL_6581, BUS_TTL_8580};
  assign expire       = 1'b0;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bus_latch <= '0;
      data_o    <= '0;
    end else begin
      if (rd) data_o <= rd_val;
      if (wr)
        bus_latch <= data_i;
      else if (rd && rd_io)
        bus_latch <= rd_val;
      else if (expire)
        bus_latch <= '0;
    end
  end
endmodule

// File: tb/tb_sid_regfile.sv
// Directed bench for sid_regfile: scoreboard queue of expected values, immediate-assertion checks.
module tb_sid_regfile;
  logic               clk = 1'b0;
  logic               res_n = 1'b0;
  logic               tick_ms = 1'b0;
  sid::model_e        model = sid::MOS6581;
  sid::phase_t        phase = 4'b0010;
  logic               cs = 1'b0, we = 1'b0;
  logic [4:0]         addr = '0;
  logic [7:0]         data_i = '0, data_o;
  logic [7:0]         pot_x_i = '0, pot_y_i = '0, osc3_i = '0, env3_i = '0;
  sid::waveform_reg_t voice_o [0:2];
  logic [16:0]        env_o   [0:2];
  logic [31:0]        filter_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  sid_regfile dut (
    .clk(clk), .res_n(res_n), .tick_ms(tick_ms), .model(model), .phase(phase),
    .cs(cs), .we(we), .addr(addr), .data_i(data_i), .data_o(data_o),
    .pot_x_i(pot_x_i), .pot_y_i(pot_y_i), .osc3_i(osc3_i), .env3_i(env3_i),
    .voice_o(voice_o), .env_o(env_o), .filter_o(filter_o)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic acc(input logic w, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; data_i = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    expect_val(64'(exp));
    acc(1'b0, a, 8'h00);
    chk(tag, 64'(data_o));
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick_ms = 1'b1;
      @(negedge clk); tick_ms = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    expect_val(64'h0); chk("rst_data_o", 64'(data_o));
    expect_val(64'h0); chk("rst_voice0", 64'(voice_o[0]));
    expect_val(64'h0); chk("rst_filter", 64'(filter_o));
    res_n = 1'b1;

    expect_val(64'h34); acc(1'b1, 5'h00, 8'h34); chk("v0_freq_lo", 64'(voice_o[0].freq_lo));
    expect_val(64'h0F); acc(1'b1, 5'h03, 8'hFF); chk("v0_pw_hi", 64'(voice_o[0].pw_hi));

    acc(1'b1, 5'h12, 8'h81);
    expect_val(64'b1000000);
    chk("v2_wave_bits", 64'({voice_o[2].noise, voice_o[2].pulse, voice_o[2].sawtooth,
                              voice_o[2].triangle, voice_o[2].test, voice_o[2].ring_mod, voice_o[2].sync}));
    expect_val(64'h10000); chk("v2_env_gate", 64'(env_o[2]));
    expect_val(64'h0);     chk("v1_untouched", 64'(voice_o[1]));

    acc(1'b1, 5'h15, 8'hFF);
    acc(1'b1, 5'h16, 8'h12);
    acc(1'b1, 5'h17, 8'h34);
    expect_val(64'h5634_1207); acc(1'b1, 5'h18, 8'h56); chk("filter", 64'(filter_o));
    expect_val(64'h5634_1207); acc(1'b1, 5'h1F, 8'h99); chk("wr_1f_noeffect", 64'(filter_o));
    rd_chk("rd_latch_1e", 5'h1E, 8'h99);

    osc3_i = 8'hA5;
    rd_chk("rd_osc3", 5'h1B, 8'hA5);
    rd_chk("rd_latch_after_osc3", 5'h00, 8'hA5);
    pot_x_i = 8'h3C; pot_y_i = 8'h6E; env3_i = 8'hC3;
    rd_chk("rd_potx", 5'h19, 8'h3C);
    rd_chk("rd_poty", 5'h1A, 8'h6E);
    rd_chk("rd_env3", 5'h1C, 8'hC3);

    phase = 4'b1101;
    expect_val(64'h34); acc(1'b1, 5'h00, 8'h77); chk("phase0_no_write", 64'(voice_o[0].freq_lo));
    phase = 4'b0010;
    rd_chk("phase0_latch_kept", 5'h1D, 8'hC3);

`ifdef SID_BUS_DECAY_EN
    model = sid::MOS6581;
    acc(1'b1, 5'h1D, 8'h5A); ticks(6); rd_chk("6581_6ticks", 5'h1D, 8'h5A);
    acc(1'b1, 5'h1D, 8'h5A); ticks(7); rd_chk("6581_7ticks", 5'h1D, 8'h00);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 5'h1D; data_i = 8'h5A; tick_ms = 1'b1;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; tick_ms = 1'b0;
    ticks(6); rd_chk("access_beats_tick", 5'h1D, 8'h5A);
    model = sid::MOS8580;
    acc(1'b1, 5'h1D, 8'h5A); ticks(663); rd_chk("8580_663ticks", 5'h1D, 8'h5A);
    acc(1'b1, 5'h1D, 8'h5A); ticks(664); rd_chk("8580_664ticks", 5'h1D, 8'h00);
    acc(1'b1, 5'h1D, 8'h5A); ticks(100);
    @(negedge clk); model = sid::MOS6581;
    @(negedge clk);
    rd_chk("model_switch_clears", 5'h1D, 8'h00);
`else
    model = sid::MOS6581;
    acc(1'b1, 5'h1D, 8'h5A); ticks(700); rd_chk("no_decay_hold", 5'h1D, 8'h5A);
`endif

    acc(1'b1, 5'h08, 8'hAB);
    @(negedge clk);
    #2 res_n = 1'b0;
    #1;
    expect_val(64'h0); chk("async_rst_data_o", 64'(data_o));
    expect_val(64'h0); chk("async_rst_voices", 64'(voice_o[0]) | 64'(voice_o[1]) | 64'(voice_o[2]));
    expect_val(64'h0); chk("async_rst_env", 64'({env_o[0], env_o[1], env_o[2]}));
    expect_val(64'h0); chk("async_rst_filter", 64'(filter_o));
    @(negedge clk); res_n = 1'b1;
    rd_chk("post_rst_latch", 5'h00, 8'h00);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
